// File: rtl/xcprint_uart.sv
// Debug character sink: bytes written on sel are queued in a small FIFO and
// shifted out as 8N1 UART frames on tx, back-to-back when the FIFO holds more.
module xcprint_uart #(
  parameter int unsigned DIV     = 434,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [7:0]       data_in,
  output logic             ready,
  output logic [FIFO_AW:0] level,
  output logic             overflow,
  output logic             busy,
  output logic             tx
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned BW    = 16;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ready_q, busy_q, overflow_q, overflow_d;
  logic            empty, full, push, pop, bit_end;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign push    = sel && !full;
  assign bit_end = (baud_q == BW'(DIV - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!empty) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_q == 3'd7) state_d = STOP;
      STOP:  if (bit_end) state_d = empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; a pop loads the shifter and restarts the baud count
  always_comb begin
    pop        = 1'b0;
    baud_d     = '0;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    overflow_d = overflow_q || (sel && full);
    if (!empty && (state_q == IDLE || (state_q == STOP && bit_end))) pop = 1'b1;
    if (!pop && state_q != IDLE) baud_d = bit_end ? '0 : baud_q + BW'(1);
    if (state_q == START && bit_end) bit_d = 3'd0;
    if (state_q == DATA && bit_end) begin
      bit_d   = bit_q + 3'd1;
      shift_d = shift_q >> 1;
    end
    if (pop) shift_d = mem_q[rd_ptr_q];
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ready_q    <= (level_d != LW'(DEPTH));
      busy_q     <= (state_d != IDLE) || (level_d != '0);
      overflow_q <= overflow_d;
    end
  end

  assign ready    = ready_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_xcprint_uart.sv
// Scoreboard bench for xcprint_uart: written bytes are queued as expected
// frames; a UART monitor on tx captures whole frames and compares them.
module tb_xcprint_uart;

  localparam int unsigned DIV   = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned FRAME = 10 * DIV;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sel = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic          ready, overflow, busy, tx;
  logic [AW:0]   level;

  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  int            n_frames = 0;
  int            m_n = 0;
  logic [7:0]    exp_q [$];
  int            starts [$];
  logic [FRAME-1:0] m_frame = '0;
  logic [7:0]    m_exp;

  xcprint_uart #(.DIV(DIV), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .sel(sel), .data_in(data_in),
    .ready(ready), .level(level), .overflow(overflow), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [FRAME-1:0] frame_of(input logic [7:0] b);
    logic [FRAME-1:0] f;
    for (int i = 0; i < FRAME; i++) begin
      int bi;
      bi = i / DIV;
      f[i] = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
    end
    return f;
  endfunction

  // Monitor: capture FRAME samples of tx from each falling start edge
  always @(negedge clk) begin
    if (!rst) begin
      m_n = 0;
    end else if (m_n == 0) begin
      if (tx === 1'b0) begin
        m_frame    = '0;
        m_frame[0] = tx;
        m_n        = 1;
        starts.push_back(cyc);
      end
    end else begin
      m_frame[m_n] = tx;
      m_n++;
      if (m_n == FRAME) begin
        m_n = 0;
        n_frames++;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          m_exp = exp_q.pop_front();
          n_vec++;
          if (m_frame !== frame_of(m_exp)) begin
            n_err++;
            $display("FAIL frame: got %h, expected %h (byte %h)", m_frame, frame_of(m_exp), m_exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input logic [7:0] b, input bit accepted);
    sel     = 1'b1;
    data_in = b;
    if (accepted) exp_q.push_back(b);
    tick();
    sel = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      if (busy === 1'b0 && m_n == 0) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) check("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, at, sidx, f0;
    logic [7:0] burst [5];
    burst = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33};

    // Reset held with sel toggling
    for (int i = 0; i < 4; i++) begin
      sel     = i[0];
      data_in = 8'hFF;
      tick();
    end
    sel = 1'b0;
    check("rst_tx", int'(tx), 1);
    check("rst_ready", int'(ready), 1);
    check("rst_level", int'(level), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    tick();
    tick();

    // Single byte 0x41
    sidx = starts.size();
    put(8'h41, 1'b1);
    k = cyc;
    check("single_level", int'(level), 1);
    check("single_busy", int'(busy), 1);
    tick();
    check("single_popped_level", int'(level), 0);
    check("single_tx_low", int'(tx), 0);
    wait_idle(100, at);
    check("single_busy_fall", at, k + 41);
    check("single_start", starts[sidx], k + 1);
    check("single_tx_idle", int'(tx), 1);

    // Burst of five bytes, fits FIFO plus the one in flight
    sidx = starts.size();
    f0   = n_frames;
    k    = cyc + 1;
    foreach (burst[i]) put(burst[i], 1'b1);
    wait_idle(400, at);
    check("burst_busy_fall", at, k + 201);
    check("burst_frames", n_frames - f0, 5);
    check("burst_overflow", int'(overflow), 0);
    check("burst_first_start", starts[sidx], k + 1);
    check("burst_contiguous", starts[sidx+4] - starts[sidx], 160);

    // Six bytes: sixth dropped while full
    f0 = n_frames;
    k  = cyc + 1;
    put(8'h11, 1'b1);
    put(8'h22, 1'b1);
    put(8'h33, 1'b1);
    put(8'h44, 1'b1);
    put(8'h55, 1'b1);
    check("ovf_full_level", int'(level), 4);
    check("ovf_ready_low", int'(ready), 0);
    check("ovf_not_yet", int'(overflow), 0);
    put(8'h66, 1'b0);
    check("ovf_set", int'(overflow), 1);
    check("ovf_level_held", int'(level), 4);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      if (ready === 1'b1) begin
        at = cyc;
        break;
      end
      tick();
    end
    check("ovf_ready_rise", at, k + 41);
    wait_idle(400, at);
    check("ovf_frames", n_frames - f0, 5);
    check("ovf_sticky", int'(overflow), 1);

    // Push in the same cycle a stop bit ends with level 1
    sidx = starts.size();
    put(8'hC3, 1'b1);
    k = cyc;
    tick();
    put(8'h3C, 1'b1);
    while (cyc < k + 40) tick();
    check("pp_level_before", int'(level), 1);
    put(8'hE7, 1'b1);
    check("pp_level_after", int'(level), 1);
    wait_idle(300, at);
    check("pp_start0", starts[sidx], k + 1);
    check("pp_gap1", starts[sidx+1] - starts[sidx], 40);
    check("pp_gap2", starts[sidx+2] - starts[sidx+1], 40);

    // Reset during data bit 3 of 0x96 (bit 3 is 0)
    put(8'h96, 1'b1);
    k = cyc;
    while (cyc < k + 18) tick();
    check("mid_tx_before", int'(tx), 0);
    rst = 1'b0;
    #1;
    check("mid_tx_async", int'(tx), 1);
    check("mid_level", int'(level), 0);
    check("mid_busy", int'(busy), 0);
    exp_q.delete();
    tick();
    tick();
    check("mid_overflow_clr", int'(overflow), 0);
    rst = 1'b1;
    tick();
    f0 = n_frames;
    put(8'h5A, 1'b1);
    wait_idle(100, at);
    check("mid_after_frames", n_frames - f0, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xcprint_uart.md
# xcprint_uart

Buffered debug-character sink on the controller data bus. It sits downstream of the address decoder's print select and replaces the simulation-only character printer with synthesizable hardware. Bytes written by the controller are queued in a small FIFO and serialized onto a UART TX line (8N1), so firmware printf output works on silicon. Firmware polls a ready flag; writes to a full FIFO are dropped and flagged.

## Interface
Parameters:
- DIV, 434: clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_AW, 4: log2 of FIFO depth (depth = 16).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- sel  in  1  write strobe from the address decoder; one byte accepted per cycle high.
- data_in  in  8  byte to print (controller write data [7:0]).
- ready  out  1  high when the FIFO is not full.
- level  out  FIFO_AW+1  number of bytes queued (0..2^FIFO_AW); excludes the byte being shifted.
- overflow  out  1  sticky; set when sel is high while full; cleared only by reset.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- tx  out  1  UART serial output, idle high.

## Operation
- Reset (rst low, asynchronous): FIFO empty, pointers 0, level=0, ready=1, overflow=0, busy=0, tx=1, FSM=IDLE, bit and baud counters 0.
- FIFO: circular buffer of 2^FIFO_AW bytes, FIFO_AW-bit read/write pointers wrapping modulo depth, separate level counter. Push when sel && !full. Pop when the FSM loads a byte.
- Simultaneous push and pop: both happen; level unchanged. When full, a same-cycle pop frees a slot, but push acceptance is decided on pre-edge full only: the byte is dropped and overflow sets.
- sel while full: byte discarded, pointers unchanged, overflow=1.
- FSM states:
  - IDLE: tx=1. If FIFO non-empty: pop head into shift register, baud=0, go START.
  - START: tx=0 for DIV cycles, then go DATA with bit index 0.
  - DATA: tx=shift[0], LSB first; every DIV cycles shift right and increment index; after 8 bits go STOP.
  - STOP: tx=1 for DIV cycles; at the end, if FIFO non-empty, pop and go START directly (no idle gap), else go IDLE.
- Baud counter counts 0..DIV-1 and wraps; a bit period ends on the cycle the counter equals DIV-1.
- tx is a registered output; no combinational path from sel or data_in to tx.
- busy = (FSM != IDLE) || (level != 0).

## Timing
- Write sampled at edge k: level increments and ready updates after edge k.
- From IDLE with empty FIFO, a write at edge k is popped at edge k+1; tx falls after edge k+1.
- Frame length exactly 10*DIV cycles: start DIV, data 8*DIV, stop DIV.
- Back-to-back queued bytes: next start bit begins the cycle after the previous stop bit ends; zero gap.
- Sustained throughput: one byte per 10*DIV cycles; FIFO absorbs bursts of up to 2^FIFO_AW bytes plus the one in flight.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously); queued bytes are lost.

## Test plan
- Reset: rst low with sel toggling -> tx=1, ready=1, level=0, overflow=0, busy=0; holds until rst high.
- Single byte, DIV=4: write 0x41 at edge k -> tx low for cycles k+1..k+4, then bits 1,0,0,0,0,0,1,0 (4 cycles each), stop high for 4; busy falls after 40 cycles.
- Burst, DIV=4, FIFO_AW=2: write 0x55,0xAA,0x0F,0xF0,0x33 on consecutive cycles -> all five frames contiguous, 200 cycles total, overflow=0.
- Overflow, DIV=4, FIFO_AW=2: write 6 bytes consecutively -> 6th dropped, overflow=1, ready=0 for the full window; 5 frames emitted.
- Push and pop together: write a byte the same cycle a stop bit ends with level=1 -> level stays 1, next frame starts with no gap.
- Mid-frame reset: assert rst during DATA bit 3 -> tx=1 within the same cycle, level=0; after release, a new byte transmits cleanly.
